// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and memory-side signal bundle for load_store_unit
interface load_store_unit_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [2:0]  cpu_option;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        cpu_response;
    logic        cpu_busy;
    logic        cpu_error;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_option;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;

    // Environment view: the core plus the Memory peripheral.
    modport master (
        output cpu_read, cpu_write, cpu_option, cpu_address, cpu_write_data,
        output mem_read_data, mem_response,
        input  cpu_read_data, cpu_response, cpu_busy, cpu_error,
        input  mem_read, mem_write, mem_option, mem_address, mem_write_data
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_option, cpu_address, cpu_write_data,
        input  mem_read_data, mem_response,
        output cpu_read_data, cpu_response, cpu_busy, cpu_error,
        output mem_read, mem_write, mem_option, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sub-word load/store adapter over a word-only memory
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of being forced aligned.
module load_store_unit #(
    parameter int RESPONSE_TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    localparam int CW = (RESPONSE_TIMEOUT > 2) ? $clog2(RESPONSE_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((RESPONSE_TIMEOUT > 0) ? RESPONSE_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   word_buf_q;
    logic [31:0]   rdata_q;
    logic [2:0]    opt_q;
    logic          is_store_q;
    logic          err_q;
    logic          resp_q;
    logic          cpu_err_q;
    logic [CW-1:0] cnt_q;

    logic          req;
    logic          req_store;
    logic          req_byte;
    logic          req_half;
    logic          req_word;
    logic [31:0]   req_addr;
    logic          trap_hit;
    logic          tmo_hit;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_value;
    logic [31:0]   wdata_merge;

    assign req       = bus.cpu_read | bus.cpu_write;
    assign req_store = bus.cpu_write & ~bus.cpu_read;
    assign req_byte  = (bus.cpu_option[1:0] == 2'b00);
    assign req_half  = (bus.cpu_option[1:0] == 2'b01);
    assign req_word  = ~req_byte & ~req_half;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_addr = bus.cpu_address;
    assign trap_hit = (req_half & bus.cpu_address[0]) | (req_word & (|bus.cpu_address[1:0]));
`else
    always_comb begin
        req_addr = bus.cpu_address;
        if (req_half) req_addr[0] = 1'b0;
        if (req_word) req_addr[1:0] = 2'b00;
    end
    assign trap_hit = 1'b0;
`endif

    assign tmo_hit = (RESPONSE_TIMEOUT > 0) && (cnt_q == TMO_LAST);

    assign ld_byte = word_buf_q[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = word_buf_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (opt_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'h000000, ld_byte};
            3'b101:  ld_value = {16'h0000, ld_half};
            default: ld_value = word_buf_q;
        endcase
    end

    // Read-modify-write merge: only B/H stores ever pass through READ with is_store_q set.
    always_comb begin
        wdata_merge = bus.mem_read_data;
        if (opt_q[1:0] == 2'b01)
            wdata_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            wdata_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_buf_q <= '0;
            rdata_q    <= '0;
            opt_q      <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            resp_q     <= 1'b0;
            cpu_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            resp_q    <= 1'b0;
            cpu_err_q <= 1'b0;
            rdata_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q     <= req_addr;
                        opt_q      <= bus.cpu_option;
                        wdata_q    <= bus.cpu_write_data;
                        is_store_q <= req_store;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        if (trap_hit) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (req_store && req_word) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.mem_response) begin
                        word_buf_q <= bus.mem_read_data;
                        cnt_q      <= '0;
                        if (is_store_q) begin
                            wdata_q <= wdata_merge;
                            state_q <= WRITE;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.mem_response) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    resp_q    <= 1'b1;
                    cpu_err_q <= err_q;
                    rdata_q   <= (is_store_q || err_q) ? 32'h0 : ld_value;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_read_data  = rdata_q;
    assign bus.cpu_response   = resp_q;
    assign bus.cpu_error      = cpu_err_q;
    assign bus.cpu_busy       = (state_q != IDLE);
    // Strobes are masked by reset so an abandoned access never reaches memory.
    assign bus.mem_read       = (state_q == READ) && !reset;
    assign bus.mem_write      = (state_q == WRITE) && !reset;
    assign bus.mem_option     = 3'b010;
    assign bus.mem_address    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_data = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
    logic clk;
    logic reset;

    load_store_unit_if bus ();

    load_store_unit #(.RESPONSE_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] mem [0:255];
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    assign bus.mem_read_data = mem[bus.mem_address[9:2]];
    assign bus.mem_response  = (bus.mem_read | bus.mem_write) && (stall_cnt >= stall_cfg);

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (bus.mem_write && bus.mem_response) begin
            mem[bus.mem_address[9:2]] <= bus.mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.mem_read && bus.mem_response) rd_cnt <= rd_cnt + 1;
        if ((bus.mem_read | bus.mem_write) && !bus.mem_response) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = addr[9:2];
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic rd, input logic wr, input logic [2:0] opt,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t e;
        int   n;
        logic seen;
        sb.push_back('{data: exp_data, err: exp_err, lat: exp_lat});
        @(negedge clk);
        bus.cpu_read       = rd;
        bus.cpu_write      = wr;
        bus.cpu_option     = opt;
        bus.cpu_address    = addr;
        bus.cpu_write_data = wd;
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.cpu_response === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_resp"}, {31'h0, seen}, 32'h1);
        chk({tag, "_data"}, bus.cpu_read_data, e.data);
        chk({tag, "_err"}, {31'h0, bus.cpu_error}, {31'h0, e.err});
        chk({tag, "_lat"}, n, e.lat);
    endtask

    initial begin
        int rd0;
        int wr0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_option     = 3'b000;
        bus.cpu_address    = 32'h0;
        bus.cpu_write_data = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", {31'h0, bus.cpu_response}, 32'h0);
        chk("rst_err", {31'h0, bus.cpu_error}, 32'h0);
        chk("rst_busy", {31'h0, bus.cpu_busy}, 32'h0);
        chk("rst_rdata", bus.cpu_read_data, 32'h0);
        chk("rst_mrd", {31'h0, bus.mem_read}, 32'h0);
        chk("rst_mwr", {31'h0, bus.mem_write}, 32'h0);
        chk("rst_mopt", {29'h0, bus.mem_option}, 32'h2);
        chk("rst_maddr", bus.mem_address, 32'h0);
        chk("rst_mwdata", bus.mem_write_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        poke(32'h100, 32'h80FF7F01);
        do_req("lb_103",  1, 0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 0, 2);
        do_req("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h00000080, 0, 2);
        do_req("lh_102",  1, 0, 3'b001, 32'h102, 32'h0, 32'hFFFF80FF, 0, 2);
        do_req("lhu_100", 1, 0, 3'b101, 32'h100, 32'h0, 32'h00007F01, 0, 2);
        do_req("lb_101",  1, 0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 0, 2);
        do_req("lw_100",  1, 0, 3'b010, 32'h100, 32'h0, 32'h80FF7F01, 0, 2);

        poke(32'h100, 32'h11223344);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sb_101", 0, 1, 3'b000, 32'h101, 32'hFFFFFFAA, 32'h0, 0, 3);
        chk("sb_rd_cnt", rd_cnt - rd0, 1);
        chk("sb_wr_cnt", wr_cnt - wr0, 1);
        chk("sb_mem", mem[8'h40], 32'h1122AA44);

        do_req("sh_102", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 0, 3);
        chk("sh_mem", mem[8'h40], 32'hBEEFAA44);

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sw_200", 0, 1, 3'b010, 32'h200, 32'hDEADBEEF, 32'h0, 0, 2);
        chk("sw_rd_cnt", rd_cnt - rd0, 0);
        chk("sw_wr_cnt", wr_cnt - wr0, 1);
        chk("sw_mem", mem[8'h80], 32'hDEADBEEF);

        stall_cfg = 3;
        do_req("lw_stall3", 1, 0, 3'b010, 32'h200, 32'h0, 32'hDEADBEEF, 0, 5);

        stall_cfg = 1000;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("sb_tmo", 0, 1, 3'b000, 32'h204, 32'h55, 32'h0, 1, 17);
        chk("tmo_wr_cnt", wr_cnt - wr0, 0);
        chk("tmo_rd_cnt", rd_cnt - rd0, 0);
        stall_cfg = 0;

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("rw_both", 1, 1, 3'b010, 32'h200, 32'h12345678, 32'hDEADBEEF, 0, 2);
        chk("both_wr_cnt", wr_cnt - wr0, 0);
        chk("both_mem", mem[8'h80], 32'hDEADBEEF);

        rd0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1);
        chk("mis_rd_cnt", rd_cnt - rd0, 0);
`else
        do_req("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'hBEEFAA44, 0, 2);
        chk("mis_rd_cnt", rd_cnt - rd0, 1);
`endif

        poke(32'h300, 32'h55667788);
        wr0 = wr_cnt;
        @(negedge clk);
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b1;
        bus.cpu_option     = 3'b001;
        bus.cpu_address    = 32'h302;
        bus.cpu_write_data = 32'h0000BEEF;
        @(posedge clk);
        #1;
        bus.cpu_write = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_in_write", {31'h0, bus.mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rstw_gated", {31'h0, bus.mem_write}, 32'h0);
        @(posedge clk);
        #1;
        chk("rstw_busy", {31'h0, bus.cpu_busy}, 32'h0);
        chk("rstw_mwr", {31'h0, bus.mem_write}, 32'h0);
        chk("rstw_mrd", {31'h0, bus.mem_read}, 32'h0);
        chk("rstw_resp", {31'h0, bus.cpu_response}, 32'h0);
        chk("rstw_maddr", bus.mem_address, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_mem", mem[8'hC0], 32'h55667788);
        chk("rstw_wr_cnt", wr_cnt - wr0, 0);

        do_req("lh_after_rst", 1, 0, 3'b101, 32'h302, 32'h0, 32'h00005566, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
